// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//   state_e       : FSM state encoding (IDLE/ARM/PLAY/OVER)
//   DIFF_*        : difficulty codes driven to game_logic
//   BCD_W         : width of one BCD digit
//   to_bcd2()     : 0..99 integer to two BCD digits
//   next_diff()   : difficulty rotation EASY -> MED -> HARD -> EASY
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_PLAY = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [3:0] DIFF_EASY = 4'h1;
  localparam logic [3:0] DIFF_MED  = 4'h2;
  localparam logic [3:0] DIFF_HARD = 4'h4;

  localparam int BCD_W = 4;

  function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned v);
    to_bcd2 = {BCD_W'(v / 32'd10), BCD_W'(v % 32'd10)};
  endfunction

  // Any unexpected code falls back to EASY so the rotation always recovers.
  function automatic logic [3:0] next_diff(input logic [3:0] d);
    case (d)
      DIFF_EASY: next_diff = DIFF_MED;
      DIFF_MED:  next_diff = DIFF_HARD;
      default:   next_diff = DIFF_EASY;
    endcase
  endfunction

endpackage

// File: rtl/wam_round_ctrl_if.sv
// Link between the round controller and game_logic.
//   start      : clear to game_logic (1 = held in clear)
//   difficulty : difficulty code
//   tap_out    : gated tap switches
//   score      : live 3-digit BCD score from game_logic
// master = controller side, slave = game_logic side.
interface wam_round_ctrl_if;
  logic        start;
  logic [3:0]  difficulty;
  logic [7:0]  tap_out;
  logic [11:0] score;

  modport master (output start, output difficulty, output tap_out, input score);
  modport slave  (input start, input difficulty, input tap_out, output score);
endinterface

// File: rtl/wam_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
//   clk, clr_n : clock and synchronous active-low reset
//   btn_i      : raw asynchronous button
//   press_o    : 1-cycle pulse when the debounced level rises
// The debounced level follows the synchronized input only after DEB_CYCLES
// consecutive samples that differ from the current level; a raw edge yields
// press_o 2 + DEB_CYCLES cycles later.
module wam_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Synchronize, count stable disagreeing samples, and flag the accepted rise.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/wam_round_ctrl.sv
// Round controller for whack-a-mole, upstream of game_logic.
//   clk, clr_n          : clock, synchronous active-low reset
//   btn_start, btn_diff : raw buttons (debounced here)
//   tap_in              : raw tap switches
//   gl                  : game_logic link (start, difficulty, tap_out, score)
//   time_left           : remaining round seconds, 2 BCD digits
//   final_score, best   : score latched at round end / best since reset
//   game_over           : high while in OVER
//   state               : current FSM state
module wam_round_ctrl
  import wam_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int ROUND_SEC  = 30,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int ARM_CYCLES = 1_048_576
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                btn_start,
  input  logic                btn_diff,
  input  logic [7:0]          tap_in,
  wam_round_ctrl_if.master    gl,
  output logic [7:0]          time_left,
  output logic [11:0]         final_score,
  output logic [11:0]         best,
  output logic                game_over,
  output logic [1:0]          state
);

  localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYCLES - 1);
  localparam logic [7:0]    ROUND_BCD = to_bcd2(ROUND_SEC);

  logic          start_p_s;
  logic          diff_p_s;
  logic [7:0]    time_dec_s;

  state_e        state_q;
  logic          start_q;
  logic [3:0]    diff_q;
  logic [7:0]    tap_sync_q;
  logic [7:0]    tap_out_q;
  logic [7:0]    time_q;
  logic [11:0]   final_q;
  logic [11:0]   best_q;
  logic          over_q;
  logic          latch_pend_q;
  logic [TW-1:0] tick_q;
  logic [AW-1:0] arm_q;

  wam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk     (clk),
    .clr_n   (clr_n),
    .btn_i   (btn_start),
    .press_o (start_p_s)
  );

  wam_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_diff (
    .clk     (clk),
    .clr_n   (clr_n),
    .btn_i   (btn_diff),
    .press_o (diff_p_s)
  );

  // Two-digit BCD decrement with borrow from the tens digit (10 -> 09).
  always_comb begin
    time_dec_s = time_q;
    if (time_q[3:0] == 4'd0) begin
      time_dec_s = {time_q[7:4] - 4'd1, 4'd9};
    end else begin
      time_dec_s = {time_q[7:4], time_q[3:0] - 4'd1};
    end
  end

  // Round FSM with all outputs held in registers; start press beats diff press.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b1;
      diff_q       <= DIFF_EASY;
      tap_sync_q   <= 8'h00;
      tap_out_q    <= 8'h00;
      time_q       <= ROUND_BCD;
      final_q      <= 12'h000;
      best_q       <= 12'h000;
      over_q       <= 1'b0;
      latch_pend_q <= 1'b0;
      tick_q       <= '0;
      arm_q        <= '0;
    end else begin
      // First synchronizer stage; the tap_out register is the second.
      tap_sync_q <= tap_in;
      case (state_q)
        ST_IDLE: begin
          if (start_p_s) begin
            state_q <= ST_ARM;
            arm_q   <= '0;
            time_q  <= ROUND_BCD;
          end else if (diff_p_s) begin
            diff_q <= next_diff(diff_q);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (arm_q == ARM_LAST) begin
            state_q <= ST_PLAY;
            start_q <= 1'b0;
            tick_q  <= '0;
          end else begin
            arm_q <= arm_q + AW'(1);
          end
        end
        ST_PLAY: begin
          tap_out_q <= tap_sync_q;
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            time_q <= time_dec_s;
            if (time_q == 8'h01) begin
              state_q      <= ST_OVER;
              tap_out_q    <= 8'h00;
              over_q       <= 1'b1;
              latch_pend_q <= 1'b1;
            end else begin
              state_q <= ST_PLAY;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        ST_OVER: begin
          // game_logic holds its score while start is low, so sampling one
          // cycle into OVER sees the final value. BCD orders like binary.
          if (latch_pend_q) begin
            final_q      <= gl.score;
            latch_pend_q <= 1'b0;
            if (gl.score > best_q) begin
              best_q <= gl.score;
            end else begin
              best_q <= best_q;
            end
          end else begin
            latch_pend_q <= 1'b0;
          end
          if (start_p_s) begin
            state_q <= ST_ARM;
            start_q <= 1'b1;
            over_q  <= 1'b0;
            arm_q   <= '0;
            time_q  <= ROUND_BCD;
          end else if (diff_p_s) begin
            diff_q <= next_diff(diff_q);
          end else begin
            state_q <= ST_OVER;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b1;
        end
      endcase
    end
  end

  assign gl.start      = start_q;
  assign gl.difficulty = diff_q;
  assign gl.tap_out    = tap_out_q;
  assign time_left     = time_q;
  assign final_score   = final_q;
  assign best          = best_q;
  assign game_over     = over_q;
  assign state         = state_q;

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Directed bench for wam_round_ctrl with TICK_DIV=10, ROUND_SEC=3,
// DEB_CYCLES=4, ARM_CYCLES=5; a second instance with ROUND_SEC=10 shares
// the button stimulus and is watched only during the first round.
module tb_wam_round_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        btn_start;
  logic        btn_diff;
  logic [7:0]  tap_in;
  logic [7:0]  time_left,  time_left2;
  logic [11:0] final_score, final_score2;
  logic [11:0] best, best2;
  logic        game_over, game_over2;
  logic [1:0]  state, state2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  wam_round_ctrl_if gl_if ();
  wam_round_ctrl_if gl_if2 ();

  wam_round_ctrl #(.TICK_DIV(10), .ROUND_SEC(3), .DEB_CYCLES(4), .ARM_CYCLES(5)) dut (
    .clk(clk), .clr_n(clr_n), .btn_start(btn_start), .btn_diff(btn_diff),
    .tap_in(tap_in), .gl(gl_if), .time_left(time_left), .final_score(final_score),
    .best(best), .game_over(game_over), .state(state)
  );

  wam_round_ctrl #(.TICK_DIV(10), .ROUND_SEC(10), .DEB_CYCLES(4), .ARM_CYCLES(5)) dut10 (
    .clk(clk), .clr_n(clr_n), .btn_start(btn_start), .btn_diff(btn_diff),
    .tap_in(tap_in), .gl(gl_if2), .time_left(time_left2), .final_score(final_score2),
    .best(best2), .game_over(game_over2), .state(state2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean diff press in IDLE: pulse lands 6 edges after the raw edge, update on the 7th.
  task automatic press_diff(input logic [3:0] exp_before, input logic [3:0] exp_after);
    btn_diff = 1'b1;
    wait_n(6);
    check_eq("diff_before", 32'(gl_if.difficulty), 32'(exp_before));
    wait_n(1);
    check_eq("diff_after", 32'(gl_if.difficulty), 32'(exp_after));
    btn_diff = 1'b0;
    wait_n(8);
  endtask

  // One full round; cycle numbers in comments count negedges after the raw start edge.
  task automatic run_round(input logic [1:0] st_before, input logic both, input logic first,
                           input logic [11:0] sc, input logic [11:0] exp_best,
                           input logic [3:0] exp_diff);
    btn_start = 1'b1;
    btn_diff  = both;
    tap_in    = 8'h00;
    wait_n(6);
    check_eq("pre_arm_state", 32'(state), 32'(st_before));
    wait_n(1);                                                   // 7
    check_eq("arm_state", 32'(state), 32'd1);
    check_eq("arm_diff", 32'(gl_if.difficulty), 32'(exp_diff));
    btn_start = 1'b0;
    btn_diff  = 1'b0;
    wait_n(4);                                                   // 11
    check_eq("arm_hold_state", 32'(state), 32'd1);
    check_eq("arm_start", 32'(gl_if.start), 32'd1);
    check_eq("arm_time", 32'(time_left), 32'h03);
    wait_n(1);                                                   // 12
    check_eq("play_state", 32'(state), 32'd2);
    check_eq("play_start", 32'(gl_if.start), 32'd0);
    tap_in = 8'hA5;
    wait_n(1);                                                   // 13
    check_eq("tap_lag1", 32'(gl_if.tap_out), 32'h00);
    wait_n(1);                                                   // 14
    check_eq("tap_lag2", 32'(gl_if.tap_out), 32'hA5);
    btn_diff = 1'b1;                                             // ignored in PLAY
    wait_n(7);                                                   // 21
    check_eq("time_03", 32'(time_left), 32'h03);
    if (first) check_eq("t10_before", 32'(time_left2), 32'h10);
    wait_n(1);                                                   // 22
    check_eq("time_02", 32'(time_left), 32'h02);
    if (first) check_eq("t10_borrow", 32'(time_left2), 32'h09);
    wait_n(2);                                                   // 24
    btn_diff    = 1'b0;
    tap_in      = 8'hFF;
    gl_if.score = sc;
    wait_n(8);                                                   // 32
    check_eq("time_01", 32'(time_left), 32'h01);
    check_eq("tap_ff", 32'(gl_if.tap_out), 32'hFF);
    wait_n(9);                                                   // 41
    check_eq("pre_over_state", 32'(state), 32'd2);
    wait_n(1);                                                   // 42
    check_eq("over_state", 32'(state), 32'd3);
    check_eq("over_time", 32'(time_left), 32'h00);
    check_eq("game_over", 32'(game_over), 32'd1);
    check_eq("over_tap", 32'(gl_if.tap_out), 32'h00);
    check_eq("over_start", 32'(gl_if.start), 32'd0);
    wait_n(1);                                                   // 43
    check_eq("final_score", 32'(final_score), 32'(sc));
    check_eq("best", 32'(best), 32'(exp_best));
    check_eq("over_tap2", 32'(gl_if.tap_out), 32'h00);
    check_eq("round_diff", 32'(gl_if.difficulty), 32'(exp_diff));
    tap_in = 8'h00;
    wait_n(3);
  endtask

  initial begin
    clr_n        = 1'b0;
    btn_start    = 1'b0;
    btn_diff     = 1'b0;
    tap_in       = 8'h00;
    gl_if.score  = 12'h000;
    gl_if2.score = 12'h000;
    wait_n(2);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_start", 32'(gl_if.start), 32'd1);
    check_eq("rst_diff", 32'(gl_if.difficulty), 32'h1);
    check_eq("rst_time", 32'(time_left), 32'h03);
    check_eq("rst_time10", 32'(time_left2), 32'h10);
    check_eq("rst_best", 32'(best), 32'h000);
    check_eq("rst_final", 32'(final_score), 32'h000);
    check_eq("rst_tap", 32'(gl_if.tap_out), 32'h00);
    check_eq("rst_over", 32'(game_over), 32'd0);
    clr_n = 1'b1;
    wait_n(2);

    press_diff(4'h1, 4'h2);
    press_diff(4'h2, 4'h4);
    press_diff(4'h4, 4'h1);
    press_diff(4'h1, 4'h2);

    // 3-cycle glitch never reaches DEB_CYCLES stable samples.
    btn_diff = 1'b1;
    wait_n(3);
    btn_diff = 1'b0;
    wait_n(10);
    check_eq("glitch_diff", 32'(gl_if.difficulty), 32'h2);

    // Round 1 with start and diff pressed together; rounds 2 and 3 restart from OVER.
    run_round(2'd0, 1'b1, 1'b1, 12'h042, 12'h042, 4'h2);
    run_round(2'd3, 1'b0, 1'b0, 12'h039, 12'h042, 4'h2);
    run_round(2'd3, 1'b0, 1'b0, 12'h105, 12'h105, 4'h2);

    // Abort mid-PLAY with reset.
    btn_start = 1'b1;
    wait_n(7);
    btn_start = 1'b0;
    wait_n(8);
    check_eq("mid_play_state", 32'(state), 32'd2);
    clr_n = 1'b0;
    wait_n(1);
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_best", 32'(best), 32'h000);
    check_eq("abort_start", 32'(gl_if.start), 32'd1);
    check_eq("abort_time", 32'(time_left), 32'h03);
    check_eq("abort_diff", 32'(gl_if.difficulty), 32'h1);
    clr_n = 1'b1;
    wait_n(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wam_round_ctrl.md
# wam_round_ctrl

Round controller for the whack-a-mole game, sitting directly upstream of `game_logic`. It debounces the start and difficulty buttons and selects the difficulty. It drives `game_logic`'s `start` (clear) and `difficulty` inputs, gates the 8 tap switches into it, and runs a BCD countdown for each round. It consumes the 3-digit BCD `score` that `game_logic` produces, latching the final score and a best score when a round ends.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per countdown second.
- `ROUND_SEC`, 30: round length in seconds; legal range 1..99.
- `DEB_CYCLES`, 1_000_000: cycles a synchronized button level must stay stable to be accepted.
- `ARM_CYCLES`, 1_048_576: cycles `start` is held high before play begins; must exceed one `clk_19` period.
- `clk`, in, 1: system clock.
- `clr_n`, in, 1: synchronous, active-low reset.
- `btn_start`, in, 1: raw start button (asynchronous).
- `btn_diff`, in, 1: raw difficulty-cycle button (asynchronous).
- `tap_in`, in, 8: raw tap switches.
- `score`, in, 12: live score from `game_logic`, 3 BCD digits.
- `start`, out, 1: clear to `game_logic`; high means held in clear.
- `difficulty`, out, 4: to `game_logic` `difficulty`.
- `tap_out`, out, 8: gated taps to `game_logic` `tap`.
- `time_left`, out, 8: 2 BCD digits of remaining seconds.
- `final_score`, out, 12: score latched at round end.
- `best`, out, 12: highest `final_score` since reset.
- `game_over`, out, 1: high in OVER.
- `state`, out, 2: current FSM state, for display and debug.

## Operation
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a stability counter.
  - The debounced level updates only after `DEB_CYCLES` consecutive equal samples.
  - A press is a 1-cycle pulse on the debounced rising edge.
- Difficulty codes: EASY=4'h1, MED=4'h2, HARD=4'h4.
  - A `btn_diff` press cycles EASY→MED→HARD→EASY.
  - Accepted only in IDLE and OVER.
- FSM states: IDLE=0, ARM=1, PLAY=2, OVER=3.
  - IDLE:
    - `start`=1, `tap_out`=0.
    - `time_left`=ROUND_SEC (BCD).
    - A start press goes to ARM.
  - ARM:
    - `start`=1, `tap_out`=0.
    - `time_left` is reloaded to ROUND_SEC.
    - The arm counter runs ARM_CYCLES cycles, then the FSM goes to PLAY.
    - Button presses are ignored.
  - PLAY:
    - `start`=0, `tap_out`=`tap_in` (synchronized through 2 FFs).
    - The tick counter counts to TICK_DIV−1, then decrements `time_left` by BCD decrement with borrow (e.g. 10→09).
    - A tick that takes `time_left` from 01 to 00 goes to OVER.
    - Button presses are ignored.
  - OVER:
    - `start`=0, so `game_logic` holds its score; `tap_out`=0; `game_over`=1.
    - A start press goes to ARM, beginning a new round at the current difficulty.
- Round-end latch, on the first OVER cycle:
  - `final_score` ← `score`.
  - If `score` > `best`, then `best` ← `score`.
  - A plain unsigned 12-bit compare is correct because BCD ordering is preserved.
- Simultaneous start and diff presses: start wins and difficulty is unchanged.

## Timing
- Reset values (`clr_n`=0 at a clk edge):
  - state=IDLE, `start`=1, `difficulty`=4'h1, `tap_out`=0.
  - `time_left`=ROUND_SEC in BCD.
  - `final_score`=0, `best`=0, `game_over`=0.
  - Debounced levels=0; all counters=0.
- Reset mid-round aborts to IDLE and also clears `best`.
- All outputs are registered.
- Press latency: a raw edge reaches the debounced pulse in 2 + DEB_CYCLES cycles. The state changes on the next edge.
- ARM→PLAY: exactly ARM_CYCLES cycles after entering ARM. `start` falls on the same edge the state becomes PLAY.
- First decrement: TICK_DIV cycles after PLAY entry. The tick counter is cleared on PLAY entry.
- OVER entry: on the edge that writes 00. `tap_out` is 0 from that edge onward. `final_score` and `best` are valid one cycle later.
- `tap_out` in PLAY lags `tap_in` by 2 cycles.

## Structure
- Package `wam_pkg`:
  - State encoding constants.
  - Difficulty codes EASY/MED/HARD.
  - BCD digit width constant.
- Sub-module `wam_debounce` (synchronizer + stability counter + rise pulse, parameter `DEB_CYCLES`), instantiated twice.
- BCD decrement is combinational logic inside the controller.

## Test plan
Run with TICK_DIV=10, ROUND_SEC=3, DEB_CYCLES=4, ARM_CYCLES=5.
- Reset: hold `clr_n`=0 for 2 cycles → `start`=1, `difficulty`=1, `time_left`=8'h03, `best`=0, `tap_out`=0, state=0.
- Difficulty cycling: 4 clean `btn_diff` presses in IDLE → `difficulty` 2,4,1,2. A glitch of 3 cycles gives no change. `btn_diff` during PLAY gives no change.
- Full round:
  - Start press → ARM for 5 cycles → PLAY with `start`=0.
  - `time_left` 03→02→01→00 at 10-cycle intervals → OVER.
  - `game_over`=1 and `tap_out`=0 even with `tap_in`=8'hFF.
- Score latch:
  - With `score`=12'h042 at round end → `final_score`=12'h042, `best`=12'h042.
  - Next round ends with 12'h039 → `best` stays 12'h042.
  - Next round ends with 12'h105 → `best`=12'h105.
- Boundary cases:
  - ROUND_SEC=10 → `time_left` goes 10→09 correctly.
  - `btn_start` and `btn_diff` pressed the same cycle in IDLE → ARM with difficulty unchanged.
  - `clr_n` low in mid-PLAY → IDLE next edge and `best`=0.
